// File: rtl/spi_reg_bank_if.sv
// Pin-level SPI bundle between an SPI controller and the register bank.
// Signals:
//   SCLK     SPI clock (CPOL=0/CPHA=0), driven by the controller
//   COPI     controller-out data, MSB first
//   cs       chip select, active low
//   CIPO     peripheral-out read data
//   cipo_oe  CIPO output enable from the peripheral
// Modports: master = controller side, slave = register bank side.
interface spi_reg_bank_if;
  logic SCLK;
  logic COPI;
  logic cs;
  logic CIPO;
  logic cipo_oe;

  modport master (output SCLK, output COPI, output cs, input CIPO, input cipo_oe);
  modport slave  (input SCLK, input COPI, input cs, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral register bank, fully synchronous to clk.
// SCLK/COPI/cs are oversampled through synchronisers; frames are
// R/W bit, 7-bit address, DATA_W data bits, MSB first. Writes commit
// when cs rises after an exact-length frame; reads shift the addressed
// register out on CIPO on SCLK falling edges.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   spi        SPI pins (slave modport)
//   reg_out    flat register bus, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse per committed write
//   wr_addr    address of the last committed write
//   frame_err  one-cycle pulse when a frame is discarded
//
// state | meaning
// IDLE  | cs high, no frame in progress
// CMD   | shifting in R/W bit and address
// WDATA | shifting in write data
// RDATA | shifting out read data on CIPO
// DONE  | exactly FRAME_W bits received
// OVER  | more than FRAME_W bits received, frame will be rejected
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic                       wr_strobe,
  output logic [6:0]                 wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 8 + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
  localparam logic [7:0]       NREGS     = 8'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE, OVER} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, cs_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, copi_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [FRAME_W-1:0]     sr;
  logic [DATA_W-1:0]      rd_sh;
  logic                   cipo_q;
  logic [DATA_W-1:0]      regs [NUM_REGS];

  logic                   cmd_rw;
  logic [6:0]             cmd_addr;
  logic [DATA_W-1:0]      rd_word;
  logic                   fr_rw;
  logic [6:0]             fr_addr;
  logic [DATA_W-1:0]      fr_data;
  logic                   fr_addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.COPI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Command byte as it will look once the current COPI bit is shifted in.
  assign cmd_rw   = sr[6];
  assign cmd_addr = {sr[5:0], copi_s};

  // Fields of a complete frame sitting in the shift register.
  assign fr_rw      = sr[FRAME_W-1];
  assign fr_addr    = sr[FRAME_W-2 -: 7];
  assign fr_data    = sr[DATA_W-1:0];
  assign fr_addr_ok = ({1'b0, fr_addr} < NREGS);

  // Address decode for read latch; out-of-range addresses read as 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == 7'(i)) rd_word = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      rd_sh     <= '0;
      cipo_q    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      // cs edges take priority; an SCLK edge in the same cycle is dropped.
      if (cs_fall) begin
        state  <= CMD;
        cnt    <= '0;
        sr     <= '0;
        cipo_q <= 1'b0;
      end else if (cs_rise) begin
        state  <= IDLE;
        cipo_q <= 1'b0;
        case (state)
          IDLE: ;
          DONE: begin
            if (!fr_addr_ok) begin
              frame_err <= 1'b1;
            end else if (fr_rw) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (fr_addr == 7'(i)) regs[i] <= fr_data;
              end
              wr_addr   <= fr_addr;
              wr_strobe <= 1'b1;
            end
          end
          default: frame_err <= 1'b1;
        endcase
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          sr  <= {sr[FRAME_W-2:0], copi_s};
          cnt <= cnt_nxt;
          case (state)
            CMD: begin
              if (cnt_nxt == CNT_CMD) begin
                if (cmd_rw) begin
                  state <= WDATA;
                end else begin
                  state <= RDATA;
                  rd_sh <= rd_word;
                end
              end
            end
            WDATA, RDATA: if (cnt_nxt == CNT_FRAME) state <= DONE;
            DONE: begin
              state  <= OVER;
              cipo_q <= 1'b0;
            end
            default: ;
          endcase
        end else if (sclk_fall && (state == RDATA || state == DONE)) begin
          cipo_q <= rd_sh[DATA_W-1];
          rd_sh  <= rd_sh << 1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

  assign spi.CIPO    = cipo_q;
  assign spi.cipo_oe = ~cs_s;

endmodule
